// File: rtl/data_bus_if_pkg.sv
// rtl/data_bus_if_pkg.sv - shared state encoding, stall indices and defaults for the data bus bridge
package data_bus_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY       = 2'd1,
    ST_WAIT_STALL = 2'd2
  } bus_state_t;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/data_bus_if_if.sv
// rtl/data_bus_if_if.sv - Wishbone-classic data bus signals with master/slave views
interface data_bus_if_if
  import data_bus_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic                wb_we_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_stb_o;
  logic                wb_cyc_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/data_bus_if_watchdog.sv
// rtl/data_bus_if_watchdog.sv - counts unacknowledged bus cycles and flags expiry
module data_bus_if_watchdog
  import data_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      cnt_inc;

  // Expiry is flagged in the cycle that would bring the count to TIMEOUT_CYC,
  // so the bridge gives up after exactly TIMEOUT_CYC silent cycles.
  assign cnt_inc = 32'(cnt) + 32'd1;
  assign expire  = (TIMEOUT_CYC != 0) && count_en && (cnt_inc == 32'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_bus_if.sv
// rtl/data_bus_if.sv - MEM-stage to Wishbone-classic bridge with flush, stall hold-off and timeout
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int STALL_W     = 6,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  data_bus_if_if.master       wb
);

  bus_state_t        state, state_nxt;
  logic [DATA_W-1:0] rd_buf;
  logic              start, ack, wd_count, wd_expire;

  assign start    = (state == ST_IDLE) && cpu_ce_i && !flush_i;
  assign ack      = (state == ST_BUSY) && !flush_i && wb.wb_ack_i;
  assign wd_count = (state == ST_BUSY) && !flush_i && !wb.wb_ack_i;

  data_bus_if_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .count_en (wd_count),
    .expire   (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT_STALL keeps a still-stalled MEM stage from launching the same access twice.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (start) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flush_i)        state_nxt = ST_IDLE;
        else if (ack)       state_nxt = (|stall_i) ? ST_WAIT_STALL : ST_IDLE;
        else if (wd_expire) state_nxt = ST_IDLE;
      end
      ST_WAIT_STALL: if (!(|stall_i) || flush_i) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = rd_buf;
    case (state)
      ST_IDLE: stallreq_o = start;
      ST_BUSY: begin
        if (flush_i) begin
          cpu_data_o = '0;
        end else if (ack) begin
          cpu_data_o = wb.wb_we_o ? rd_buf : wb.wb_dat_i;
        end else begin
          cpu_data_o = '0;
          stallreq_o = !wd_expire;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= '0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      rd_buf      <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= wd_expire;
      if (start) begin
        wb.wb_adr_o <= cpu_addr_i;
        wb.wb_dat_o <= cpu_data_i;
        wb.wb_we_o  <= cpu_we_i;
        wb.wb_sel_o <= cpu_sel_i;
        wb.wb_stb_o <= 1'b1;
        wb.wb_cyc_o <= 1'b1;
      end else if ((state == ST_BUSY) && (flush_i || ack || wd_expire)) begin
        wb.wb_we_o  <= 1'b0;
        wb.wb_sel_o <= '0;
        wb.wb_stb_o <= 1'b0;
        wb.wb_cyc_o <= 1'b0;
        // Aborted or flushed accesses must not leave stale load data behind.
        if (!ack) begin
          rd_buf <= '0;
        end else if (!wb.wb_we_o) begin
          rd_buf <= wb.wb_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_if.sv
// tb/tb_data_bus_if.sv - scoreboard bench for the MEM-to-Wishbone data bus bridge
module tb_data_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;

  data_bus_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_bus_if #(.DATA_W(32), .ADDR_W(32), .STALL_W(6), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input string tag, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input int hold);
    exp_t e, r;
    int   busy_n, stalls, lat, starts, post;
    bit   acked, ack_now, done;
    logic prev_cyc;
    busy_n = 0; stalls = 0; lat = 0; starts = 0; post = 0;
    acked = 0; done = 0; prev_cyc = 1'b0;
    e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.stalls = waits + 1; e.lat = waits + 2;
    sb.push_back(e);
    r = e;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = addr; cpu_data_i = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      ack_now = bus.wb_cyc_o && !acked && (busy_n == waits);
      bus.wb_ack_i = ack_now;
      bus.wb_dat_i = ack_now ? rdata : (32'hBAD0_0000 | 32'(c));
      stall_i = ((ack_now || acked) && post < hold) ? 6'b000011 : 6'b000000;
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (bus.wb_cyc_o && !prev_cyc) starts++;
      prev_cyc = bus.wb_cyc_o;
      if (bus.wb_cyc_o && busy_n == 0) begin
        chk({tag, "_adr"}, bus.wb_adr_o, sb[0].addr);
        chk({tag, "_sel"}, 32'(bus.wb_sel_o), 32'(sb[0].sel));
        chk({tag, "_we"}, 32'(bus.wb_we_o), 32'(sb[0].we));
        chk({tag, "_stb"}, 32'(bus.wb_stb_o), 32'd1);
        if (sb[0].we) chk({tag, "_dat"}, bus.wb_dat_o, sb[0].wdata);
      end
      if (ack_now) begin
        lat = c + 1;
        r = sb.pop_front();
        if (!r.we) chk({tag, "_ack_data"}, cpu_data_o, r.rdata);
      end else if (bus.wb_cyc_o && busy_n == 0) begin
        chk({tag, "_busy_data"}, cpu_data_o, 32'h0);
      end
      if (acked && post >= 1 && post <= hold) begin
        chk({tag, "_wait_cyc"}, 32'(bus.wb_cyc_o), 32'd0);
        chk({tag, "_wait_stallreq"}, 32'(stallreq_o), 32'd0);
        if (!r.we) chk({tag, "_wait_data"}, cpu_data_o, r.rdata);
      end
      if (ack_now || acked) begin
        if (stall_i == 6'b0) done = 1;
        post++;
        acked = 1;
      end
      if (bus.wb_cyc_o) busy_n++;
      tick();
    end
    cpu_ce_i = 1'b0; bus.wb_ack_i = 1'b0; stall_i = 6'b0;
    if (!done) chk({tag, "_done"}, 32'd0, 32'd1);
    if (!acked) r = sb.pop_front();
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(r.stalls));
    chk({tag, "_latency"}, 32'(lat), 32'(r.lat));
    chk({tag, "_bus_cycles"}, 32'(starts), 32'd1);
    if (!r.we) last_load = r.rdata;
    @(negedge clk);
    chk({tag, "_idle_data"}, cpu_data_o, last_load);
    chk({tag, "_idle_cyc"}, 32'(bus.wb_cyc_o), 32'd0);
    tick();
  endtask

  initial begin
    int busy, errs, stalls;
    bit drop;
    rst = 1'b1; stall_i = 6'b0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_sel_i = 4'h0; cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
    repeat (3) tick();
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    chk("rst_data", cpu_data_o, 32'h0);
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;
    tick();

    access("load0", 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 0);
    access("store", 1'b1, 4'b0100, 32'h0000_1002, 32'hABABABAB, 32'h0, 3, 0);
    access("ldhold", 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hCAFEF00D, 1, 2);

    // synchronous reset in the middle of a bus cycle
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'hF; cpu_addr_i = 32'h2000; cpu_data_i = 32'h5555AAAA;
    tick();
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.wb_cyc_o), 32'd1);
    tick();
    rst = 1'b1; cpu_ce_i = 1'b0;
    tick();
    chk("rst_mid_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_mid_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_mid_dat", bus.wb_dat_o, 32'h0);
    chk("rst_mid_data", cpu_data_o, 32'h0);
    chk("rst_mid_stallreq", 32'(stallreq_o), 32'd0);
    rst = 1'b0; last_load = 32'h0;
    tick();
    access("post_rst", 1'b0, 4'h3, 32'h0000_2004, 32'h0, 32'h13579BDF, 1, 0);

    // flush in the second BUSY cycle, then a stray ACK
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF; cpu_addr_i = 32'h3000;
    tick();
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stallreq", 32'(stallreq_o), 32'd0);
    chk("flush_cyc_before", 32'(bus.wb_cyc_o), 32'd1);
    tick();
    flush_i = 1'b0; cpu_ce_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h12345678;
    @(negedge clk);
    chk("flush_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("flush_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("flush_data", cpu_data_o, 32'h0);
    tick();
    bus.wb_ack_i = 1'b0;
    @(negedge clk);
    chk("stray_ack_data", cpu_data_o, 32'h0);
    chk("stray_ack_cyc", 32'(bus.wb_cyc_o), 32'd0);
    last_load = 32'h0;
    tick();

    // no ACK at all: watchdog abort
    busy = 0; errs = 0; stalls = 0; drop = 0;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF; cpu_addr_i = 32'h4000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) busy++;
      if (bus_err_o) errs++;
      if (stallreq_o) stalls++;
      if (!stallreq_o) drop = 1;
      tick();
      if (drop) cpu_ce_i = 1'b0;
    end
    chk("tmo_busy_cycles", 32'(busy), 32'd4);
    chk("tmo_err_pulses", 32'(errs), 32'd1);
    chk("tmo_stall_cycles", 32'(stalls), 32'd4);
    @(negedge clk);
    chk("tmo_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("tmo_data", cpu_data_o, 32'h0);
    tick();

    access("recover", 1'b0, 4'hC, 32'h0000_5008, 32'h0, 32'h0F1E2D3C, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
